// File: rtl/debug_bridge.sv
// debug_bridge: byte-stream to debug-bus bridge.
// A command frame is one address byte followed by eight data bytes (LE).
// The word is issued on the debug bus to the addressed slave, the slave's
// 64-bit response is captured and returned as a status byte plus eight
// data bytes (LE).
// Optional feature: define DEBUG_BRIDGE_TIMEOUT_EN to abort a bus
// transaction after TIMEOUT_CYCLES cycles in ISSUE/WAIT (status 8'hEE).
module debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  IDLE_ADDR      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [7:0]  bus_addr,
  output logic        bus_start,
  inout  wire  [63:0] bus_data,
  input  logic        bus_accepted,
  input  logic        bus_available
);

  typedef enum logic [2:0] {
    RX_ADDR, RX_DATA, ISSUE, WAIT, TX_STATUS, TX_DATA
  } state_t;

  state_t      state;
  logic [7:0]  addr;
  logic [7:0]  status;
  logic [63:0] req_word;
  logic [63:0] rsp_word;
  logic [2:0]  cnt;
  logic        accepted;
  logic        available;

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tcnt;
`endif

  // Bus handshakes are treated as asserted only on a clean 1; x/z count as 0.
  assign accepted  = (bus_accepted === 1'b1);
  assign available = (bus_available === 1'b1);

  // Outputs are pure decodes of the state register and latched data.
  assign rx_ready  = (state == RX_ADDR) || (state == RX_DATA);
  assign tx_valid  = (state == TX_STATUS) || (state == TX_DATA);
  assign bus_start = (state == ISSUE);
  assign bus_addr  = ((state == ISSUE) || (state == WAIT)) ? addr : IDLE_ADDR;
  // The bridge only ever drives the shared data bus while issuing.
  assign bus_data  = (state == ISSUE) ? req_word : 64'hz;

  // Response byte mux; holds while stalled because its sources only move on a transfer.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      TX_STATUS: tx_data = status;
      TX_DATA:   tx_data = rsp_word[{cnt, 3'b000} +: 8];
      default:   tx_data = 8'h00;
    endcase
  end

  // Main control FSM: receive frame, issue on bus, wait for response, reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_ADDR;
      addr     <= 8'h00;
      status   <= 8'h00;
      req_word <= 64'h0;
      rsp_word <= 64'h0;
      cnt      <= 3'd0;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      case (state)
        RX_ADDR: begin
          if (rx_valid && rx_ready) begin
            addr  <= rx_data;
            cnt   <= 3'd0;
            state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_valid && rx_ready) begin
            req_word[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= ISSUE;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end
          end
        end
        ISSUE: begin
          // bus_available is deliberately ignored until the request is accepted
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
          if (tcnt == TLAST) begin
            rsp_word <= 64'h0;
            status   <= 8'hEE;
            state    <= TX_STATUS;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (accepted) state <= WAIT;
          end
`else
          if (accepted) state <= WAIT;
`endif
        end
        WAIT: begin
          // A response arriving on the final timeout cycle still completes normally
          if (available) begin
            rsp_word <= bus_data;
            status   <= 8'h00;
            state    <= TX_STATUS;
          end
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
          else if (tcnt == TLAST) begin
            rsp_word <= 64'h0;
            status   <= 8'hEE;
            state    <= TX_STATUS;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        TX_STATUS: begin
          if (tx_ready) begin
            cnt   <= 3'd0;
            state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= RX_ADDR;
          end
        end
        default: state <= RX_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bridge.sv
// tb_debug_bridge: randomized scoreboard bench for debug_bridge.
// Driver issues frames and pushes the expected bus request and reply bytes;
// a stub slave checks bus requests, and a monitor checks reply bytes.
module tb_debug_bridge;
  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_ready, bus_accepted, bus_available;
  logic [7:0]  rx_data, tx_data, bus_addr;
  logic        rx_ready, tx_valid, bus_start;
  wire  [63:0] bus_data;
  logic        slave_drive;
  logic [63:0] slave_val;

  assign bus_data = slave_drive ? slave_val : 64'hz;
  always #5 clk = ~clk;

  debug_bridge #(.TIMEOUT_CYCLES(16), .IDLE_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_start(bus_start), .bus_data(bus_data),
    .bus_accepted(bus_accepted), .bus_available(bus_available)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  b [8];
    logic [63:0] word;
    logic [63:0] resp;
    int          acc_dly;
    int          avl_dly;
    bit          no_resp;
  } txn_t;

  txn_t       slave_q[$];
  logic [7:0] exp_tx[$];
  int         tests = 0;
  int         fails = 0;
  bit         toggle_mode = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: LE packing of frame bytes and expected reply stream.
  function automatic txn_t make_txn(input logic [7:0] a, input logic [63:0] resp,
                                    input int acc, input int avl, input bit nr);
    txn_t t;
    t.addr = a; t.resp = resp; t.acc_dly = acc; t.avl_dly = avl; t.no_resp = nr;
    t.word = 64'h0;
    for (int i = 0; i < 8; i++) t.b[i] = 8'($urandom);
    return t;
  endfunction

  function automatic logic [63:0] pack_le(input txn_t t);
    logic [63:0] w = 64'h0;
    for (int i = 0; i < 8; i++) w = w + (64'(t.b[i]) << (8 * i));
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 3000) begin check("rx_ready_wait", 64'(rx_ready), 64'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input txn_t t, input bit b2b);
    txn_t s = t;
    s.word = pack_le(t);
    slave_q.push_back(s);
    send_byte(t.addr);
    for (int i = 0; i < 8; i++) begin
      if (!b2b && ($urandom_range(0, 3) == 0)) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_byte(t.b[i]);
    end
    if (!b2b) rx_valid = 1'b0;
    if (t.no_resp) begin
      exp_tx.push_back(8'hEE);
      for (int i = 0; i < 8; i++) exp_tx.push_back(8'h00);
    end else begin
      exp_tx.push_back(8'h00);
      for (int i = 0; i < 8; i++) exp_tx.push_back(t.resp[8 * i +: 8]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_tx.size() != 0 || slave_q.size() != 0) && n < 5000) begin
      @(posedge clk); n++;
    end
    if (n >= 5000) check("idle_wait", 64'(exp_tx.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Sink-side ready pattern: alternating or random.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = toggle_mode ? ~tx_ready : ($urandom_range(0, 3) != 0);
    end
  end

  // Reply monitor: pops expected bytes on each tx transfer, checks stall hold.
  always @(negedge clk) begin
    logic [7:0] e;
    if (prev_stall) begin
      check("tx_hold_valid", 64'(tx_valid), 64'd1);
      check("tx_hold_data", 64'(tx_data), 64'(prev_data));
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_tx.pop_front();
        check("tx_byte", 64'(tx_data), 64'(e));
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (rx_valid && rx_ready) begin
      check("rx_while_reply", 64'(exp_tx.size()), 64'd0);
      check("idle_addr", 64'(bus_addr), 64'hFF);
    end
  end

  // Stub slave: checks each request against the expected frame and responds.
  initial begin
    txn_t t;
    bus_accepted = 1'b0; bus_available = 1'b0; slave_drive = 1'b0; slave_val = 64'h0;
    forever begin
      @(negedge clk);
      if (bus_start) begin
        if (slave_q.size() == 0) begin
          check("bus_unexpected", 64'd1, 64'd0);
          continue;
        end
        t = slave_q.pop_front();
        check("bus_addr", 64'(bus_addr), 64'(t.addr));
        check("bus_data", bus_data, t.word);
        if (t.no_resp) begin
          int c = 0;
          while (bus_start && c < 100) begin c++; @(negedge clk); end
          check("timeout_cycles", 64'(c), 64'd16);
          continue;
        end
        for (int k = 0; k < t.acc_dly; k++) begin
          @(posedge clk); #1;
          bus_available = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("hold_start", 64'(bus_start), 64'd1);
          check("hold_data", bus_data, t.word);
        end
        @(posedge clk); #1;
        bus_accepted = 1'b1; bus_available = 1'b0;
        @(posedge clk); #1;
        bus_accepted = 1'b0;
        @(negedge clk);
        check("start_drop", 64'(bus_start), 64'd0);
        check("wait_addr", 64'(bus_addr), 64'(t.addr));
        repeat (t.avl_dly) begin @(posedge clk); #1; end
        slave_val = t.resp; slave_drive = 1'b1; bus_available = 1'b1;
        @(posedge clk); #1;
        bus_available = 1'b0; slave_drive = 1'b0;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    txn_t t;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_bus_start", 64'(bus_start), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'hFF);
    @(posedge clk); #1;

    // Directed frame: 02 / 01 00 12 00 00 00 00 AB.
    t = make_txn(8'h02, 64'hFFFFFFFFFFFFFF5A, 1, 0, 1'b0);
    t.b = '{8'h01, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};
    check("directed_word", pack_le(t), 64'hAB00000000120001);
    send_frame(t, 1'b0);
    wait_idle();

    // Slow accept: request held for 5 cycles.
    send_frame(make_txn(8'h11, 64'h0123456789ABCDEF, 5, 2, 1'b0), 1'b0);
    wait_idle();

    // Alternating tx_ready across a whole reply.
    toggle_mode = 1'b1;
    send_frame(make_txn(8'h22, 64'($urandom) << 32 | 64'($urandom), 0, 1, 1'b0), 1'b0);
    wait_idle();
    toggle_mode = 1'b0;

    // Reset after 4 data bytes, then a complete frame to 02.
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bus_start", 64'(bus_start), 64'd0);
    check("midrst_rx_ready", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;
    send_frame(make_txn(8'h02, 64'h5555AAAA0000FFFF, 1, 1, 1'b0), 1'b0);
    wait_idle();

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    // No slave answers address 07: abort after 16 cycles.
    send_frame(make_txn(8'h07, 64'h0, 0, 0, 1'b1), 1'b0);
    wait_idle();
`endif

    // Random frames, some back-to-back with rx_valid held high.
    for (int f = 0; f < 20; f++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 254));
      send_frame(make_txn(a, 64'($urandom) << 32 | 64'($urandom),
                          $urandom_range(0, 5), $urandom_range(0, 3), 1'b0),
                 1'($urandom_range(0, 1)));
    end
    rx_valid = 1'b0;
    wait_idle();
    check("bus_leftover", 64'(slave_q.size()), 64'd0);
    check("tx_leftover", 64'(exp_tx.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
